// File: rtl/gpio_bank.sv
// Multi-channel GPIO peripheral on the CPU I/O bus: per-channel data/direction registers,
// synchronised inputs, rising-edge interrupt status (W1C) and a combined IRQ line.
module gpio_bank #(
    parameter int unsigned NUM_CH    = 2,
    parameter int unsigned WIDTH     = 31,
    parameter int unsigned ADDR_BITS = 9,
    parameter int unsigned BASE_ADDR = 60
) (
    input  logic                      CLK,
    input  logic                      Reset,
    input  logic [ADDR_BITS-1:0]      AddressIO,
    input  logic                      WriteIO,
    input  logic [31:0]               WriteData,
    output logic [31:0]               ReadData,
    output logic                      Hit,
    input  logic [NUM_CH*WIDTH-1:0]   GPIO_In,
    output logic [NUM_CH*WIDTH-1:0]   GPIO_Out,
    output logic [NUM_CH*WIDTH-1:0]   GPIO_OE,
    output logic                      IRQ
);

    localparam int unsigned CH_W = ADDR_BITS - 3;

    localparam logic [2:0] OFF_DATA_OUT   = 3'd0;
    localparam logic [2:0] OFF_DIR        = 3'd1;
    localparam logic [2:0] OFF_DATA_IN    = 3'd2;
    localparam logic [2:0] OFF_IRQ_EN     = 3'd3;
    localparam logic [2:0] OFF_IRQ_STATUS = 3'd4;

    logic [WIDTH-1:0] data_out   [NUM_CH];
    logic [WIDTH-1:0] dir        [NUM_CH];
    logic [WIDTH-1:0] irq_en     [NUM_CH];
    logic [WIDTH-1:0] irq_status [NUM_CH];
    logic [WIDTH-1:0] s1         [NUM_CH];
    logic [WIDTH-1:0] s2         [NUM_CH];
    logic [WIDTH-1:0] prev       [NUM_CH];

    logic [ADDR_BITS-1:0] rel;
    logic [CH_W-1:0]      rel_ch;
    logic [2:0]           off;
    logic                 in_range;
    logic [NUM_CH-1:0]    sel;
    logic [WIDTH-1:0]     wdata;
    logic [WIDTH-1:0]     rd_c;
    logic                 irq_c;
    logic                 unused_wdata;

    generate
        if (WIDTH < 32) begin : g_drop
            assign unused_wdata = ^WriteData[31:WIDTH];
        end else begin : g_full
            assign unused_wdata = 1'b0;
        end
    endgenerate

    // Address decode: channel in the upper bits above BASE_ADDR, register offset in the low 3
    always_comb begin
        rel      = AddressIO - ADDR_BITS'(BASE_ADDR);
        rel_ch   = rel[ADDR_BITS-1:3];
        off      = rel[2:0];
        in_range = (AddressIO >= ADDR_BITS'(BASE_ADDR)) &&
                   (rel_ch < CH_W'(NUM_CH)) &&
                   (off <= OFF_IRQ_STATUS);
        wdata    = WriteData[WIDTH-1:0];
        sel      = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            sel[c] = in_range && (rel_ch == CH_W'(c));
        end
    end

    // Read mux and combined interrupt, both registered below
    always_comb begin
        rd_c  = '0;
        irq_c = 1'b0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (sel[c]) begin
                case (off)
                    OFF_DATA_OUT:   rd_c = data_out[c];
                    OFF_DIR:        rd_c = dir[c];
                    OFF_DATA_IN:    rd_c = s2[c];
                    OFF_IRQ_EN:     rd_c = irq_en[c];
                    OFF_IRQ_STATUS: rd_c = irq_status[c];
                    default:        rd_c = '0;
                endcase
            end
            irq_c = irq_c | (|(irq_status[c] & irq_en[c]));
        end
    end

    always_comb begin
        GPIO_Out = '0;
        GPIO_OE  = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            GPIO_Out[c*WIDTH +: WIDTH] = data_out[c];
            GPIO_OE[c*WIDTH +: WIDTH]  = dir[c];
        end
    end

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            for (int c = 0; c < NUM_CH; c++) begin
                data_out[c]   <= '0;
                dir[c]        <= '0;
                irq_en[c]     <= '0;
                irq_status[c] <= '0;
                s1[c]         <= '0;
                s2[c]         <= '0;
                prev[c]       <= '0;
            end
            ReadData <= '0;
            Hit      <= 1'b0;
            IRQ      <= 1'b0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                s1[c]   <= GPIO_In[c*WIDTH +: WIDTH];
                s2[c]   <= s1[c];
                prev[c] <= s2[c];
                // A new enabled rise overrides a simultaneous W1C of the same bit
                if (WriteIO && sel[c] && (off == OFF_IRQ_STATUS)) begin
                    irq_status[c] <= (irq_status[c] & ~wdata) | (s2[c] & ~prev[c] & irq_en[c]);
                end else begin
                    irq_status[c] <= irq_status[c] | (s2[c] & ~prev[c] & irq_en[c]);
                end
                if (WriteIO && sel[c]) begin
                    case (off)
                        OFF_DATA_OUT: data_out[c] <= wdata;
                        OFF_DIR:      dir[c]      <= wdata;
                        OFF_IRQ_EN:   irq_en[c]   <= wdata;
                        default:      ;
                    endcase
                end
            end
            ReadData <= 32'(rd_c);
            Hit      <= in_range;
            IRQ      <= irq_c;
        end
    end

endmodule

// File: tb/tb_gpio_bank.sv
// Bench for gpio_bank: fixed vector table, hand-built corner sequences and a randomized run
// compared every cycle against a register-level model with a sampled-pad history.
module tb_gpio_bank;

    localparam int unsigned NCH  = 2;
    localparam int unsigned W    = 31;
    localparam int unsigned AB   = 9;
    localparam int unsigned BASE = 60;
    localparam int unsigned PW   = NCH * W;

    logic          clk = 1'b0;
    logic          rst;
    logic [AB-1:0] addr_io;
    logic          we;
    logic [31:0]   wdata;
    logic [31:0]   rdata;
    logic          hit;
    logic [PW-1:0] pins;
    logic [PW-1:0] gpio_out;
    logic [PW-1:0] gpio_oe;
    logic          irq;

    int checks = 0;
    int errors = 0;

    gpio_bank #(.NUM_CH(NCH), .WIDTH(W), .ADDR_BITS(AB), .BASE_ADDR(BASE)) dut (
        .CLK(clk), .Reset(rst), .AddressIO(addr_io), .WriteIO(we), .WriteData(wdata),
        .ReadData(rdata), .Hit(hit), .GPIO_In(pins), .GPIO_Out(gpio_out), .GPIO_OE(gpio_oe),
        .IRQ(irq)
    );

    always #5 clk = ~clk;

    // Reference state: register contents plus the pads as sampled at the last three edges
    logic [W-1:0]  mdo [NCH];
    logic [W-1:0]  mdir[NCH];
    logic [W-1:0]  men [NCH];
    logic [W-1:0]  mst [NCH];
    logic [PW-1:0] h0, h1, h2;
    logic [31:0]   mrd;
    logic          mhit, mirq;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < NCH; c++) begin
            mdo[c] = '0; mdir[c] = '0; men[c] = '0; mst[c] = '0;
        end
        h0 = '0; h1 = '0; h2 = '0;
        mrd = '0; mhit = 1'b0; mirq = 1'b0;
    endtask

    task automatic model_edge(input int a, input bit w, input logic [31:0] d, input logic [PW-1:0] p);
        int c, o;
        bit ok;
        logic [W-1:0]  rv, dw;
        logic [W-1:0]  nst[NCH];
        logic [PW-1:0] rise;
        bit nirq;
        ok = 0; c = 0; o = 0;
        if (a >= int'(BASE)) begin
            c  = (a - int'(BASE)) / 8;
            o  = (a - int'(BASE)) % 8;
            ok = (c < int'(NCH)) && (o <= 4);
        end
        dw = d[W-1:0];
        rv = '0;
        if (ok) begin
            case (o)
                0: rv = mdo[c];
                1: rv = mdir[c];
                2: rv = h1[c*W +: W];
                3: rv = men[c];
                default: rv = mst[c];
            endcase
        end
        nirq = 0;
        rise = h1 & ~h2;
        for (int k = 0; k < NCH; k++) begin
            if ((mst[k] & men[k]) != '0) nirq = 1;
            nst[k] = mst[k];
            if (ok && w && o == 4 && k == c) nst[k] = nst[k] & ~dw;
            nst[k] = nst[k] | (rise[k*W +: W] & men[k]);
        end
        if (ok && w) begin
            if (o == 0) mdo[c]  = dw;
            if (o == 1) mdir[c] = dw;
            if (o == 3) men[c]  = dw;
        end
        for (int k = 0; k < NCH; k++) mst[k] = nst[k];
        h2 = h1; h1 = h0; h0 = p;
        mrd = {1'b0, rv}; mhit = ok; mirq = nirq;
    endtask

    function automatic logic [PW-1:0] pack(input logic [W-1:0] v[NCH]);
        logic [PW-1:0] r;
        r = '0;
        for (int c = 0; c < NCH; c++) r[c*W +: W] = v[c];
        return r;
    endfunction

    // One bus cycle: drive at the falling edge, model the rising edge, compare at the next fall
    task automatic step(input int a, input bit w, input logic [31:0] d, input logic [PW-1:0] p);
        addr_io = AB'(a); we = w; wdata = d; pins = p;
        @(posedge clk);
        model_edge(a, w, d, p);
        @(negedge clk);
        check("rdata", 64'(rdata), 64'(mrd));
        check("hit", 64'(hit), 64'(mhit));
        check("irq", 64'(irq), 64'(mirq));
        check("gpio_out", 64'(gpio_out), 64'(pack(mdo)));
        check("gpio_oe", 64'(gpio_oe), 64'(pack(mdir)));
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_out"}, 64'(gpio_out), 64'h0);
        check({tag, "_oe"}, 64'(gpio_oe), 64'h0);
        check({tag, "_irq"}, 64'(irq), 64'h0);
        check({tag, "_rdata"}, 64'(rdata), 64'h0);
        check({tag, "_hit"}, 64'(hit), 64'h0);
    endtask

    // Reset held 3 cycles with pads toggling; called at a falling edge
    task automatic do_reset();
        rst = 1'b1;
        #1;
        model_reset();
        check_zero_outputs("rst_assert");
        for (int i = 0; i < 3; i++) begin
            pins = PW'({$urandom(), $urandom()});
            @(negedge clk);
            check_zero_outputs("rst_hold");
        end
        rst = 1'b0;
    endtask

    typedef struct {
        int          a;
        bit          w;
        logic [31:0] d;
        logic [31:0] rd;
        bit          h;
    } vec_t;

    vec_t tbl[$];
    logic [PW-1:0] p;
    logic [63:0]   r;

    initial begin
        rst = 1'b1; addr_io = '0; we = 1'b0; wdata = '0; pins = '0;
        @(negedge clk);
        do_reset();

        // Expected read data is the register value before the write of the same cycle
        tbl.push_back('{68, 1'b1, 32'h2AAAAAAA, 32'h0,        1'b1});
        tbl.push_back('{69, 1'b1, 32'h7FFFFFFF, 32'h0,        1'b1});
        tbl.push_back('{68, 1'b0, 32'h0,        32'h2AAAAAAA, 1'b1});
        tbl.push_back('{69, 1'b0, 32'h0,        32'h7FFFFFFF, 1'b1});
        tbl.push_back('{60, 1'b1, 32'hFFFFFFFF, 32'h0,        1'b1});
        tbl.push_back('{60, 1'b0, 32'h0,        32'h7FFFFFFF, 1'b1});
        tbl.push_back('{59, 1'b1, 32'h00000123, 32'h0,        1'b0});
        tbl.push_back('{65, 1'b1, 32'hFFFFFFFF, 32'h0,        1'b0});
        tbl.push_back('{66, 1'b1, 32'hFFFFFFFF, 32'h0,        1'b0});
        tbl.push_back('{67, 1'b1, 32'hFFFFFFFF, 32'h0,        1'b0});
        tbl.push_back('{76, 1'b1, 32'hFFFFFFFF, 32'h0,        1'b0});
        tbl.push_back('{77, 1'b1, 32'hFFFFFFFF, 32'h0,        1'b0});
        tbl.push_back('{60, 1'b0, 32'h0,        32'h7FFFFFFF, 1'b1});
        tbl.push_back('{62, 1'b1, 32'h00000055, 32'h0,        1'b1});
        tbl.push_back('{62, 1'b0, 32'h0,        32'h0,        1'b1});
        tbl.push_back('{61, 1'b0, 32'h0,        32'h0,        1'b1});
        tbl.push_back('{70, 1'b0, 32'h0,        32'h0,        1'b1});
        tbl.push_back('{69, 1'b0, 32'h0,        32'h7FFFFFFF, 1'b1});
        foreach (tbl[i]) begin
            step(tbl[i].a, tbl[i].w, tbl[i].d, '0);
            check($sformatf("tbl%0d_rdata", i), 64'(rdata), 64'(tbl[i].rd));
            check($sformatf("tbl%0d_hit", i), 64'(hit), 64'(tbl[i].h));
        end
        check("ch1_out", 64'(gpio_out), {2'b0, 31'h2AAAAAAA, 31'h7FFFFFFF});
        check("ch1_oe", 64'(gpio_oe), {2'b0, 31'h7FFFFFFF, 31'h0});

        // Input synchroniser latency
        p = '0; p[3:0] = 4'h5;
        step(62, 0, 0, p);
        check("sync_e1", 64'(rdata), 64'h0);
        step(62, 0, 0, p);
        step(62, 0, 0, p);
        check("sync_e3", 64'(rdata), 64'h5);

        // Enabled rise on pin 0: status at edge 3, IRQ at edge 4, then W1C
        for (int i = 0; i < 4; i++) step(64, 0, 0, '0);
        step(63, 1, 32'h1, '0);
        p = '0; p[0] = 1'b1;
        step(64, 0, 0, p);
        step(64, 0, 0, p);
        step(64, 0, 0, p);
        check("edge3_irq", 64'(irq), 64'h0);
        step(64, 0, 0, p);
        check("edge4_status", 64'(rdata), 64'h1);
        check("edge4_irq", 64'(irq), 64'h1);
        step(64, 1, 32'h1, p);
        step(64, 0, 0, p);
        check("w1c_irq", 64'(irq), 64'h0);
        check("w1c_status", 64'(rdata), 64'h0);

        // W1C landing on the same edge as a new rise: the set wins
        for (int i = 0; i < 3; i++) step(64, 0, 0, '0);
        step(64, 0, 0, p);
        step(64, 0, 0, p);
        step(64, 1, 32'h1, p);
        step(64, 0, 0, p);
        check("setwins_status", 64'(rdata), 64'h1);
        check("setwins_irq", 64'(irq), 64'h1);

        // Disabling the pin keeps the pending status
        step(63, 1, 32'h0, p);
        step(64, 0, 0, p);
        check("en_off_status", 64'(rdata), 64'h1);

        // Half-cycle reset pulse in the middle of operation
        step(63, 1, 32'h1, p);
        step(60, 1, 32'h1234, p);
        step(61, 1, 32'hF0, p);
        addr_io = AB'(64); we = 1'b0; wdata = '0;
        @(posedge clk);
        model_edge(64, 0, 0, p);
        #1 rst = 1'b1;
        model_reset();
        #1 check_zero_outputs("midrst");
        #3 rst = 1'b0;
        @(negedge clk);
        step(64, 0, 0, p);
        check("midrst_status", 64'(rdata), 64'h0);
        step(60, 0, 0, p);
        check("midrst_dout", 64'(rdata), 64'h0);

        // Randomized traffic around the mapped window, with one reset in the middle
        p = '0;
        for (int i = 0; i < 600; i++) begin
            r = {$urandom(), $urandom()} & {$urandom(), $urandom()} & {$urandom(), $urandom()};
            p = p ^ r[PW-1:0];
            if (i == 300) begin
                do_reset();
            end
            step(int'($urandom_range(56, 80)), bit'($urandom_range(0, 1)), $urandom(), p);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
